// File: rtl/fp32_pkg.sv
// Shared constants, encodings and stage payload types for the fp32 -> int32 converter.
package fp32_pkg;

   typedef enum logic [1:0] {
      RM_RNE = 2'd0,
      RM_RTZ = 2'd1,
      RM_RUP = 2'd2,
      RM_RDN = 2'd3
   } rmode_e;

   typedef enum logic [1:0] {
      CLS_ZERO   = 2'd0,
      CLS_FINITE = 2'd1,
      CLS_INF    = 2'd2,
      CLS_NAN    = 2'd3
   } fp_cls_e;

   localparam int unsigned FLG_INV = 4;
   localparam int unsigned FLG_DZ  = 3;
   localparam int unsigned FLG_OF  = 2;
   localparam int unsigned FLG_UF  = 1;
   localparam int unsigned FLG_INX = 0;

   localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN    = 32'h8000_0000;
   localparam int          FP32_BIAS    = 127;
   localparam int          FP32_MANT_W  = 23;
   localparam logic [7:0]  FP32_EXP_INF = 8'hFF;

   // Exponent at which the significand LSB has weight 2^0.
   localparam logic [9:0]  FP32_INT_OFS = 10'(FP32_BIAS + FP32_MANT_W);

   typedef struct packed {
      logic        sign;
      fp_cls_e     cls;
      logic [23:0] sig;
      logic [9:0]  shamt;
      rmode_e      rmode;
   } s1_t;

   typedef struct packed {
      logic        sign;
      fp_cls_e     cls;
      logic [31:0] mag;
      logic        guard;
      logic        sticky;
      logic        range;
      rmode_e      rmode;
   } s2_t;

   function automatic fp_cls_e fp32_classify(input logic [7:0] exp, input logic [22:0] man);
      if (exp == FP32_EXP_INF) return (man != '0) ? CLS_NAN : CLS_INF;
      if (exp == 8'd0 && man == '0) return CLS_ZERO;
      return CLS_FINITE;
   endfunction

endpackage

// File: rtl/fp32_int_align.sv
// Combinational alignment of a 24-bit significand to a 32-bit integer magnitude,
// producing guard/sticky for right shifts and a range flag for oversize left shifts.
module fp32_int_align
   import fp32_pkg::*;
(
   input  logic [23:0] sig_i,
   input  logic [9:0]  shamt_i,
   output logic [31:0] mag_o,
   output logic        guard_o,
   output logic        sticky_o,
   output logic        range_o
);

   logic [48:0] ext;
   logic [9:0]  rsh;

   always_comb begin
      mag_o    = '0;
      guard_o  = 1'b0;
      sticky_o = 1'b0;
      range_o  = 1'b0;
      ext      = '0;
      rsh      = '0;
      if (!shamt_i[9]) begin
         if ($signed(shamt_i) > 10'sd8) begin
            range_o = 1'b1;
         end else begin
            mag_o = {8'b0, sig_i} << shamt_i[3:0];
         end
      end else begin
         rsh = -shamt_i;
         if (rsh > 10'd25) begin
            sticky_o = |sig_i;
         end else begin
            // 25 fraction bits below the significand catch guard and sticky.
            ext      = {sig_i, 25'b0} >> rsh[4:0];
            mag_o    = {8'b0, ext[48:25]};
            guard_o  = ext[24];
            sticky_o = |ext[23:0];
         end
      end
   end

endmodule

// File: rtl/fp32_to_int32_conv.sv
// Three-stage fp32 -> int32 converter: unpack/classify, align, round/saturate.
// One stall domain: every stage advances only when the output slot can move.
module fp32_to_int32_conv
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [1:0]  rmode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [4:0]  flags
);

   logic        advance;
   logic        s1_valid_q, s2_valid_q, s3_valid_q;
   s1_t         s1_d, s1_q;
   s2_t         s2_d, s2_q;
   logic [31:0] result_d, result_q;
   logic [4:0]  flags_d, flags_q;

   logic [7:0]  exp;
   logic [7:0]  exp_eff;
   logic        inc;
   logic [32:0] rnd;
   logic        oor;

   assign advance   = !s3_valid_q || out_ready;
   assign in_ready  = advance;
   assign out_valid = s3_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

   always_comb begin
      exp        = a[30:23];
      exp_eff    = (exp == 8'd0) ? 8'd1 : exp;
      s1_d.sign  = a[31];
      s1_d.cls   = fp32_classify(exp, a[22:0]);
      s1_d.sig   = {exp != 8'd0, a[22:0]};
      s1_d.shamt = {2'b00, exp_eff} - FP32_INT_OFS;
      s1_d.rmode = rmode_e'(rmode);
   end

   fp32_int_align u_align (
      .sig_i    (s1_q.sig),
      .shamt_i  (s1_q.shamt),
      .mag_o    (s2_d.mag),
      .guard_o  (s2_d.guard),
      .sticky_o (s2_d.sticky),
      .range_o  (s2_d.range)
   );

   assign s2_d.sign  = s1_q.sign;
   assign s2_d.cls   = s1_q.cls;
   assign s2_d.rmode = s1_q.rmode;

   always_comb begin
      inc = 1'b0;
      unique case (s2_q.rmode)
         RM_RNE: inc = s2_q.guard & (s2_q.sticky | s2_q.mag[0]);
         RM_RTZ: inc = 1'b0;
         RM_RUP: inc = !s2_q.sign & (s2_q.guard | s2_q.sticky);
         RM_RDN: inc = s2_q.sign & (s2_q.guard | s2_q.sticky);
         default: inc = 1'b0;
      endcase
      rnd = {1'b0, s2_q.mag} + {32'b0, inc};
      // Negative side reaches one further: -2^31 is representable.
      oor = s2_q.range | (s2_q.sign ? (rnd > 33'h0_8000_0000) : (rnd > 33'h0_7FFF_FFFF));

      result_d = '0;
      flags_d  = '0;
      unique case (s2_q.cls)
         CLS_ZERO: begin
            result_d = '0;
         end
         CLS_NAN: begin
            result_d         = INT32_MIN;
            flags_d[FLG_INV] = 1'b1;
         end
         CLS_INF: begin
            result_d         = s2_q.sign ? INT32_MIN : INT32_MAX;
            flags_d[FLG_INV] = 1'b1;
         end
         CLS_FINITE: begin
            if (oor) begin
               result_d         = s2_q.sign ? INT32_MIN : INT32_MAX;
               flags_d[FLG_INV] = 1'b1;
            end else begin
               result_d         = s2_q.sign ? (~rnd[31:0] + 32'd1) : rnd[31:0];
               flags_d[FLG_INX] = s2_q.guard | s2_q.sticky;
            end
         end
         default: result_d = '0;
      endcase
      flags_d[FLG_DZ] = 1'b0;
      flags_d[FLG_OF] = 1'b0;
      flags_d[FLG_UF] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
         result_q   <= '0;
         flags_q    <= '0;
      end else if (advance) begin
         s1_valid_q <= in_valid;
         s2_valid_q <= s1_valid_q;
         s3_valid_q <= s2_valid_q;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp32_to_int32_conv.sv
// Scoreboard bench for fp32_to_int32_conv: directed operands, queued expectations,
// independent output monitor, plus backpressure, latency and reset scenarios.
module tb_fp32_to_int32_conv;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [1:0]  rmode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  flags;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_acc  = 0;

   logic [68:0] exp_q[$];   // {operand, result, flags}

   fp32_to_int32_conv dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .rmode     (rmode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic send(input logic [31:0] av, input logic [1:0] rm, input logic [31:0] er,
                       input logic [4:0] ef, input bit push);
      int waitc;
      waitc    = 0;
      in_valid = 1'b1;
      a        = av;
      rmode    = rm;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waitc++;
         if (waitc > 50) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      n_acc++;
      if (push) exp_q.push_back({av, er, ef});
      #1;
      in_valid = 1'b0;
   endtask

   task automatic measure_latency(input string name);
      int lat;
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      chk(name, 32'(lat), 32'd3);
   endtask

   // Monitor: compare on each transfer, check hold stability while stalled.
   logic        held_v = 1'b0;
   logic [31:0] held_r;
   logic [4:0]  held_f;
   logic [68:0] ent;

   always @(negedge clk) begin
      if (rst && out_valid) begin
         if (held_v) begin
            chk("stall_result_stable", result, held_r);
            chk("stall_flags_stable", {27'b0, flags}, {27'b0, held_f});
         end
         if (out_ready) begin
            held_v = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 32'd1, 32'd0);
            end else begin
               ent = exp_q.pop_front();
               n_cmp++;
               if (result !== ent[36:5] || flags !== ent[4:0]) begin
                  n_fail++;
                  $display("FAIL conv a=%h: got result %h flags %b, expected result %h flags %b",
                           ent[68:37], result, flags, ent[36:5], ent[4:0]);
               end
            end
         end else begin
            held_v = 1'b1;
            held_r = result;
            held_f = flags;
         end
      end else begin
         held_v = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vcnt;
      int drain;
      rst       = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      rmode     = 2'd0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
      chk("reset_result", result, 32'd0);
      chk("reset_flags", {27'b0, flags}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      send(32'h3FC0_0000, 2'd0, 32'h0000_0002, 5'b00001, 1'b1);
      measure_latency("latency_first");
      @(posedge clk);
      #1;

      send(32'h3FC0_0000, 2'd1, 32'h0000_0001, 5'b00001, 1'b1);
      send(32'h3FC0_0000, 2'd3, 32'h0000_0001, 5'b00001, 1'b1);
      send(32'h3FC0_0000, 2'd2, 32'h0000_0002, 5'b00001, 1'b1);
      send(32'h4020_0000, 2'd0, 32'h0000_0002, 5'b00001, 1'b1);
      send(32'hBFC0_0000, 2'd3, 32'hFFFF_FFFE, 5'b00001, 1'b1);
      send(32'hBFC0_0000, 2'd2, 32'hFFFF_FFFF, 5'b00001, 1'b1);
      send(32'hCF00_0000, 2'd0, 32'h8000_0000, 5'b00000, 1'b1);
      send(32'h4F00_0000, 2'd0, 32'h7FFF_FFFF, 5'b10000, 1'b1);
      send(32'h7FC0_0000, 2'd0, 32'h8000_0000, 5'b10000, 1'b1);
      send(32'hFF80_0000, 2'd0, 32'h8000_0000, 5'b10000, 1'b1);
      send(32'h7F80_0000, 2'd1, 32'h7FFF_FFFF, 5'b10000, 1'b1);
      send(32'h0000_0001, 2'd2, 32'h0000_0001, 5'b00001, 1'b1);
      send(32'h0000_0001, 2'd0, 32'h0000_0000, 5'b00001, 1'b1);
      send(32'h8000_0000, 2'd0, 32'h0000_0000, 5'b00000, 1'b1);
      send(32'h42F6_0000, 2'd0, 32'h0000_007B, 5'b00000, 1'b1);
      send(32'hC2F6_0000, 2'd0, 32'hFFFF_FF85, 5'b00000, 1'b1);
      send(32'hCF00_0001, 2'd1, 32'h8000_0000, 5'b10000, 1'b1);
      send(32'h4EFF_FFFF, 2'd0, 32'h7FFF_FF80, 5'b00000, 1'b1);
      send(32'h3F00_0000, 2'd0, 32'h0000_0000, 5'b00001, 1'b1);
      send(32'h3F00_0000, 2'd2, 32'h0000_0001, 5'b00001, 1'b1);
      repeat (5) @(posedge clk);
      #1;

      // Backpressure: five operands against a blocked consumer.
      out_ready = 1'b0;
      n_acc     = 0;
      fork
         begin
            send(32'h4040_0000, 2'd0, 32'h0000_0003, 5'b00000, 1'b1);
            send(32'h4080_0000, 2'd0, 32'h0000_0004, 5'b00000, 1'b1);
            send(32'h40A0_0000, 2'd0, 32'h0000_0005, 5'b00000, 1'b1);
            send(32'h40C0_0000, 2'd0, 32'h0000_0006, 5'b00000, 1'b1);
            send(32'h40E0_0000, 2'd0, 32'h0000_0007, 5'b00000, 1'b1);
         end
         begin
            repeat (8) @(posedge clk);
            @(negedge clk);
            chk("bp_accepted", 32'(n_acc), 32'd3);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      chk("bp_drained", 32'(exp_q.size()), 32'd0);

      // Reset with two operands in flight.
      send(32'h4110_0000, 2'd0, 32'h0000_0009, 5'b00000, 1'b0);
      send(32'h4120_0000, 2'd0, 32'h0000_000A, 5'b00000, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_flags", {27'b0, flags}, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      vcnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) vcnt++;
      end
      chk("postrst_no_stale", 32'(vcnt), 32'd0);
      @(posedge clk);
      #1;
      send(32'h4130_0000, 2'd0, 32'h0000_000B, 5'b00000, 1'b1);
      measure_latency("latency_after_reset");

      drain = 0;
      while (exp_q.size() != 0 && drain < 50) begin
         @(posedge clk);
         drain++;
      end
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fp32_to_int32_conv.md
# fp32_to_int32_conv

Pipelined converter from IEEE754 single precision to signed 32-bit two's-complement integer. It has four rounding modes, saturation and IEEE-style exception flags. It is the return path of the single-precision add/sub datapath: float results leave the FP units through this block as integer data. Valid/ready handshakes are used on both sides, with three pipeline stages and full-pipeline backpressure.

## Interface
Parameters:
- none. Widths are fixed at 32 and all constants come from the shared package.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operand present
- in_ready  output  1  converter accepts the operand this cycle
- a  input  32  IEEE754 single-precision operand
- rmode  input  2  rounding mode, sampled together with `a`: 0 = RNE, 1 = RTZ, 2 = RUP (toward +inf), 3 = RDN (toward -inf)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result this cycle
- result  output  32  signed integer
- flags  output  5  {invalid, divzero, overflow, underflow, inexact}; divzero, overflow and underflow are always 0

## Operation
Pipeline stages:
- S1 (unpack/classify): split sign, exp and mantissa. Form the significand {hidden, m}, with hidden = (exp != 0); denormals therefore use hidden = 0 and an effective exp of 1. Classify the operand as NaN, Inf, zero, or finite. Compute the signed shift d = exp_eff - 150.
- S2 (align, in sub-module):
  - d >= 0: shift the significand left by d into a 32-bit magnitude. This case is only reachable for exp <= 158; for larger exp set the range flag.
  - d < 0: shift right by -d and keep guard = the first bit shifted out and sticky = OR of the remaining shifted-out bits. For -d > 25 the magnitude is 0, guard is 0, and sticky = (significand != 0).
- S3 (round/sign/saturate):
  - Increment decision per mode: RNE = guard & (sticky | lsb); RTZ = 0; RUP = !sign & (guard | sticky); RDN = sign & (guard | sticky).
  - Add the increment to the magnitude, then negate if sign is set.
- Out-of-range rules:
  - The result is out of range if the rounded magnitude exceeds 2^31-1 for positive operands, or 2^31 for negative operands.
  - Positive Inf or positive out of range gives 0x7FFFFFFF.
  - Negative Inf, negative out of range, or any NaN gives 0x80000000.
  - Each of these cases sets invalid = 1 and inexact = 0.
- Exact -2^31 (0xCF000000) gives 0x80000000 with no flags.
- inexact = (guard | sticky) for every in-range finite result. It is set even when the result rounds to zero.
- Zero of either sign gives 0 with no flags.

## Timing
- Latency: exactly 3 cycles from acceptance to out_valid when there is no stall. Throughput is 1 per cycle.
- Acceptance: an operand is accepted when in_valid & in_ready at a rising edge. A result transfers when out_valid & out_ready.
- Stall rule:
  - Define advance = !out_valid | out_ready. In this single-stall-domain design, in_ready = advance.
  - All stage registers, including each stage's valid bit, load only when advance = 1.
  - When advance = 0, every stage holds its contents.
  - Bubbles are not compressed.
- Stability: while out_valid = 1 and out_ready = 0, result and flags hold stable.
- Reset (rst low): all stage valid bits go to 0, so out_valid = 0, result = 0 and flags = 0 immediately and asynchronously. in_ready goes to 1.
- Reset mid-operation: in-flight operands are discarded and no partial result is ever presented. The first operand accepted after reset release produces a result 3 cycles later.
- Simultaneous accept and emit in the same cycle is allowed; no data is lost or duplicated.
- Result order always matches input order.

## Structure
- Shared package `fp32_pkg`:
  - rounding-mode encodings: RM_RNE, RM_RTZ, RM_RUP, RM_RDN
  - flag bit indices: FLG_INV = 4 … FLG_INX = 0
  - constants INT32_MAX and INT32_MIN, FP32_BIAS = 127, FP32_EXP_INF = 8'hFF
  - class encoding for zero, finite, Inf and NaN
- Sub-module `fp32_int_align`: the combinational S2 barrel shifter. Inputs are the 24-bit significand and the signed shift. Outputs are the 32-bit magnitude, guard, sticky and the range flag.
- Top level holds the handshake logic, the three stage registers, and the S1/S3 logic.

## Test plan
- 0x3FC00000 (1.5): RNE gives 2, RTZ gives 1, RDN gives 1, all with flags 5'b00001. 0x40200000 (2.5) with RNE gives 2 (tie to even), inexact.
- 0xBFC00000 (-1.5): RDN gives 0xFFFFFFFE (-2), RUP gives 0xFFFFFFFF (-1), both inexact.
- 0xCF000000 gives 0x80000000 with flags 0. 0x4F000000 (2^31) gives 0x7FFFFFFF with flags 5'b10000. 0x7FC00000 (NaN) gives 0x80000000 with flags 5'b10000. 0xFF800000 (-Inf) gives 0x80000000 with flags 5'b10000.
- Denormal 0x00000001: RUP gives 1, RNE gives 0, both with flags 5'b00001. 0x80000000 (-0) gives 0 with flags 0.
- Backpressure:
  - Hold out_ready = 0 and drive 5 back-to-back operands.
  - Exactly 3 are accepted, then in_ready drops.
  - Release out_ready: all 5 results appear in order, and result stays stable while stalled.
- Reset: assert rst low with 2 operands in flight. out_valid drops immediately and nothing from before reset emerges. An operand after release yields a result at exactly +3 cycles.
